// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC SPI write path.
package dac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_DOWN,
    CLK_HIGH,
    CLK_LOW,
    CS_UP,
    LDAC,
    DONE
  } state_t;

  localparam int          CMD_W_DEF    = 8;
  localparam int          DATA_W_DEF   = 16;
  localparam logic [7:0]  WRITE_UPDATE = 8'h30;

  function automatic int frame_w(input int cmd_w, input int data_w);
    return cmd_w + data_w;
  endfunction

  localparam int FRAME_W = frame_w(CMD_W_DEF, DATA_W_DEF);

endpackage

// File: rtl/dac_tick_cnt.sv
// Loadable 8-bit down-counter; done is high while the count sits at zero.
module dac_tick_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign done = (cnt == 8'd0);

endmodule

// File: rtl/dac_writer.sv
// SPI mode-0 master: shifts {cmd, signed code} MSB first under SYNC_n, then pulses LDAC_n.
// Outputs are registered from the next state, so they change on the same edge as the state.
module dac_writer
  import dac_pkg::*;
#(
  parameter int CMD_W   = 8,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2,
  parameter int LDAC_W  = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [CMD_W-1:0]         cmd_i,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic                     start_i,
  output logic                     is_idle_o,
  output logic                     spi_clk_o,
  output logic                     spi_mosi_o,
  output logic                     sync_n_o,
  output logic                     ldac_n_o
);

  localparam int         FW       = frame_w(CMD_W, DATA_W);
  localparam int         BW       = $clog2(FW);
  localparam logic [7:0] DIV_FULL = 8'(CLK_DIV);
  localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [7:0] LDAC_M1  = 8'(LDAC_W - 1);

  state_t          state, state_d;
  logic [FW-1:0]   shift, shift_d;
  logic [BW-1:0]   bit_cnt, bit_cnt_d;
  logic            tick_load;
  logic [7:0]      tick_val;
  logic            tick_done;
  logic            in_frame;

  dac_tick_cnt u_tick (
    .clk      (clk_i),
    .reset    (reset_i),
    .load     (tick_load),
    .load_val (tick_val),
    .done     (tick_done)
  );

  // CS_DOWN is loaded with the full divider: one extra SYNC_n-to-SCLK setup cycle.
  always_comb begin
    state_d   = state;
    shift_d   = shift;
    bit_cnt_d = bit_cnt;
    tick_load = 1'b0;
    tick_val  = DIV_M1;
    case (state)
      IDLE: if (start_i) begin
        state_d   = CS_DOWN;
        shift_d   = {cmd_i, data_i};
        bit_cnt_d = BW'(FW - 1);
        tick_load = 1'b1;
        tick_val  = DIV_FULL;
      end
      CS_DOWN: if (tick_done) begin
        state_d   = CLK_HIGH;
        tick_load = 1'b1;
      end
      CLK_HIGH: if (tick_done) begin
        state_d   = CLK_LOW;
        shift_d   = {shift[FW-2:0], 1'b0};
        tick_load = 1'b1;
      end
      CLK_LOW: if (tick_done) begin
        tick_load = 1'b1;
        if (bit_cnt != '0) begin
          bit_cnt_d = bit_cnt - BW'(1);
          state_d   = CLK_HIGH;
        end else begin
          state_d = CS_UP;
        end
      end
      CS_UP: if (tick_done) begin
        state_d   = LDAC;
        tick_load = 1'b1;
        tick_val  = LDAC_M1;
      end
      LDAC: if (tick_done) begin
        state_d = DONE;
      end
      DONE: if (!start_i) begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_frame = (state_d == CS_DOWN) || (state_d == CLK_HIGH) || (state_d == CLK_LOW);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      spi_clk_o  <= 1'b0;
      spi_mosi_o <= 1'b0;
      sync_n_o   <= 1'b1;
      ldac_n_o   <= 1'b1;
      is_idle_o  <= 1'b1;
    end else begin
      state      <= state_d;
      shift      <= shift_d;
      bit_cnt    <= bit_cnt_d;
      spi_clk_o  <= (state_d == CLK_HIGH);
      spi_mosi_o <= in_frame ? shift_d[FW-1] : 1'b0;
      sync_n_o   <= !in_frame;
      ldac_n_o   <= (state_d != LDAC);
      is_idle_o  <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_dac_writer.sv
// Bench for dac_writer: SPI slave model plus frame timing derived from the frame rules.
module tb_dac_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cmd0, cmd1;
  logic [15:0] data0, data1;
  logic        start0, start1;
  logic        o0_idle, o0_clk, o0_mosi, o0_sync, o0_ldac;
  logic        o1_idle, o1_clk, o1_mosi, o1_sync, o1_ldac;

  always #5 clk = ~clk;

  dac_writer u_dut0 (
    .clk_i(clk), .reset_i(rst), .cmd_i(cmd0), .data_i(data0), .start_i(start0),
    .is_idle_o(o0_idle), .spi_clk_o(o0_clk), .spi_mosi_o(o0_mosi),
    .sync_n_o(o0_sync), .ldac_n_o(o0_ldac)
  );

  dac_writer #(.CLK_DIV(1)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .cmd_i(cmd1), .data_i(data1), .start_i(start1),
    .is_idle_o(o1_idle), .spi_clk_o(o1_clk), .spi_mosi_o(o1_mosi),
    .sync_n_o(o1_sync), .ldac_n_o(o1_ldac)
  );

  int tests = 0, fails = 0;
  int cyc = 0, start_cyc = 0;
  bit sel = 1'b0;
  logic s_clk, s_mosi, s_sync, s_ldac, s_idle;
  logic prev_clk, prev_sync, prev_ldac;
  logic [23:0] cap;
  int rises, bad_rise, sclk_bad, sync_low, sync_falls, ldac_low, ldac_first, idle_cnt;
  int hi_run, max_hi, min_hi, first_rise, last_rise;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    prev_clk = 1'b0; prev_sync = 1'b1; prev_ldac = 1'b1;
    cap = '0; rises = 0; bad_rise = 0; sclk_bad = 0; sync_low = 0; sync_falls = 0;
    ldac_low = 0; ldac_first = 0; idle_cnt = 0;
    hi_run = 0; max_hi = 0; min_hi = 1000; first_rise = 0; last_rise = 0;
  endtask

  // One system clock; the slave model samples the selected DUT 1 time unit after the edge.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    s_clk  = sel ? o1_clk  : o0_clk;
    s_mosi = sel ? o1_mosi : o0_mosi;
    s_sync = sel ? o1_sync : o0_sync;
    s_ldac = sel ? o1_ldac : o0_ldac;
    s_idle = sel ? o1_idle : o0_idle;
    if (s_clk && !prev_clk) begin
      if (!s_sync) begin
        cap = {cap[22:0], s_mosi};
        rises++;
        if (rises == 1) first_rise = cyc;
        last_rise = cyc;
      end else begin
        bad_rise++;
      end
    end
    if (s_clk && s_sync) sclk_bad++;
    if (s_clk) hi_run++;
    else if (prev_clk) begin
      if (hi_run > max_hi) max_hi = hi_run;
      if (hi_run < min_hi) min_hi = hi_run;
      hi_run = 0;
    end
    if (!s_sync) sync_low++;
    if (!s_sync && prev_sync) sync_falls++;
    if (!s_ldac) begin
      if (ldac_low == 0) ldac_first = cyc;
      ldac_low++;
    end
    if (s_idle) idle_cnt++;
    prev_clk = s_clk; prev_sync = s_sync; prev_ldac = s_ldac;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input bit which, input logic [7:0] c, input logic [15:0] d);
    sel = which;
    clear_stats();
    if (which) begin cmd1 = c; data1 = d; start1 = 1'b1; end
    else       begin cmd0 = c; data0 = d; start0 = 1'b1; end
    start_cyc = cyc + 1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_frame(input int ldac_target, input int budget);
    int n = 0;
    bit ok;
    while (!(ldac_low >= ldac_target && prev_ldac) && n < budget) begin tick(); n++; end
    ok = (ldac_low >= ldac_target && prev_ldac);
    chk("frame_end", 32'(ok), 32'd1);
  endtask

  task automatic wait_rises(input int k, input int budget);
    int n = 0;
    bit ok;
    while (rises < k && n < budget) begin tick(); n++; end
    ok = (rises >= k);
    chk("reach_bit", 32'(ok), 32'd1);
  endtask

  // Expected timing: SYNC_n setup (CLK_DIV+1), two half-periods per bit, SYNC_n hold.
  function automatic int exp_lat(input int div);
    return div * (2 * 24 + 2) + 1;
  endfunction

  initial begin
    int viol;
    logic [7:0]  rc;
    logic [15:0] rd;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    cmd0 = '0; data0 = '0; cmd1 = '0; data1 = '0;
    clear_stats();
    ticks(3);
    rst = 1'b0;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({o0_clk, o0_mosi, o0_sync, o0_ldac, o0_idle} !== 5'b00111) viol++;
    end
    chk("rst_sclk", 32'(o0_clk), 32'd0);
    chk("rst_mosi", 32'(o0_mosi), 32'd0);
    chk("rst_sync", 32'(o0_sync), 32'd1);
    chk("rst_ldac", 32'(o0_ldac), 32'd1);
    chk("rst_idle", 32'(o0_idle), 32'd1);
    chk("idle_hold", 32'(viol), 32'd0);
    chk("rst_idle1", {o1_clk, o1_mosi, o1_sync, o1_ldac, o1_idle}, 32'b00111);

    // Directed default frame.
    pulse(1'b0, 8'h30, 16'h8001);
    wait_frame(1, 400);
    chk("a_cap", cap, 32'h308001);
    chk("a_rises", rises, 24);
    chk("a_bad_rise", bad_rise, 0);
    chk("a_sclk_nosync", sclk_bad, 0);
    chk("a_lat", ldac_first - start_cyc, exp_lat(2));
    chk("a_ldac_w", ldac_low, 2);
    ticks(2);
    chk("a_idle", 32'(s_idle), 32'd1);

    // Random frames against {cmd, data}.
    for (int i = 0; i < 4; i++) begin
      rc = 8'($urandom); rd = 16'($urandom);
      pulse(1'b0, rc, rd);
      wait_frame(1, 400);
      chk("r_cap", cap, {8'h0, rc, rd});
      chk("r_rises", rises, 24);
      chk("r_lat", ldac_first - start_cyc, exp_lat(2));
      ticks(2);
    end

    // Fastest divider, all-ones code.
    pulse(1'b1, 8'h30, 16'hFFFF);
    wait_frame(1, 400);
    chk("f_cap", cap, 32'h30FFFF);
    chk("f_max_hi", max_hi, 1);
    chk("f_min_hi", min_hi, 1);
    chk("f_period", last_rise - first_rise, 46);
    chk("f_sync_low", sync_low, 50);
    chk("f_lat", ldac_first - start_cyc, exp_lat(1));
    ticks(2);

    // start held high: one frame only, idle returns the cycle after start drops.
    sel = 1'b0; clear_stats();
    cmd0 = 8'h30; data0 = 16'h5A5A; start0 = 1'b1;
    ticks(300);
    chk("h_frames", sync_falls, 1);
    chk("h_cap", cap, 32'h305A5A);
    chk("h_idle_hi", 32'(s_idle), 32'd0);
    start0 = 1'b0;
    tick();
    chk("h_idle_back", 32'(s_idle), 32'd1);
    ticks(2);

    // Data changes mid-frame must not leak in.
    pulse(1'b0, 8'h30, 16'h0F0F);
    wait_rises(5, 200);
    data0 = 16'h1234;
    wait_frame(1, 400);
    chk("l_cap", cap, 32'h300F0F);
    ticks(2);
    pulse(1'b0, 8'h30, 16'h1234);
    wait_frame(1, 400);
    chk("l_cap2", cap, 32'h301234);
    ticks(2);

    // Reset mid-frame aborts without LDAC.
    pulse(1'b0, 8'hA5, 16'hC3C3);
    wait_rises(10, 200);
    rst = 1'b1;
    tick();
    chk("x_sync", 32'(s_sync), 32'd1);
    chk("x_sclk", 32'(s_clk), 32'd0);
    chk("x_ldac", 32'(s_ldac), 32'd1);
    rst = 1'b0;
    ticks(150);
    chk("x_no_ldac", ldac_low, 0);
    rc = 8'($urandom); rd = 16'($urandom);
    pulse(1'b0, rc, rd);
    wait_frame(1, 400);
    chk("x_cap", cap, {8'h0, rc, rd});
    chk("x_rises", rises, 24);
    ticks(2);

    // Two starts separated by a single low cycle.
    sel = 1'b0; clear_stats();
    cmd0 = 8'h30; data0 = 16'h00FF; start0 = 1'b1;
    wait_frame(2, 400);
    tick();
    start0 = 1'b0;
    tick();
    data0 = 16'h7E81; start0 = 1'b1;
    wait_frame(4, 400);
    start0 = 1'b0;
    chk("b_frames", sync_falls, 2);
    chk("b_rises", rises, 48);
    chk("b_idle_gap", 32'(idle_cnt >= 1), 32'd1);
    chk("b_cap", cap, 32'h307E81);
    ticks(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
